// File: rtl/game_speed_ctrl_if.sv
// game_speed_ctrl_if: button, game clock and rate/tick signals between player side and speed control
interface game_speed_ctrl_if;
  logic btn_faster;
  logic btn_slower;
  logic btn_pause;
  logic clk_game;
  logic [1:0] clk_rate;
  logic tick;
  logic paused;
  logic rate_changed;
  modport master (output btn_faster, btn_slower, btn_pause, clk_game, input clk_rate, tick, paused, rate_changed);
  modport slave (input btn_faster, btn_slower, btn_pause, clk_game, output clk_rate, tick, paused, rate_changed);
endinterface

// File: rtl/game_speed_ctrl.sv
// game_speed_ctrl: debounced speed/pause buttons driving clk_rate, plus pause-gated game tick from clk_game
module game_speed_ctrl #(
  parameter int DEBOUNCE_CYCLES = 1_000_000
) (
  input logic clk,
  input logic rst,
  game_speed_ctrl_if.slave bus
);
  localparam logic [23:0] LAST = 24'(DEBOUNCE_CYCLES - 1);
  typedef enum logic {RUN, PAUSED} state_t;
  state_t state;
  logic [2:0] raw, press;
  logic [1:0] rate;
  logic paused, tick, rate_changed, g1, g2, g3, run, dec, inc;
  assign raw = {bus.btn_pause, bus.btn_slower, bus.btn_faster};
  for (genvar b = 0; b < 3; b++) begin : g_btn
    logic m1, s, stable, p;
    logic [23:0] cnt;
    assign press[b] = p;
    always_ff @(posedge clk or posedge rst)
      if (rst) begin
        m1 <= 1'b0;
        s <= 1'b0;
        stable <= 1'b0;
        p <= 1'b0;
        cnt <= '0;
      end else begin
        m1 <= raw[b];
        s <= m1;
        p <= s && !stable && cnt == LAST;
        if (s == stable) cnt <= '0;
        else if (cnt == LAST) begin
          stable <= s;
          cnt <= '0;
        end else cnt <= cnt + 24'd1;
      end
  end
  assign run = state == RUN;
  assign dec = press[0] && !press[1] && run && rate != 2'd0;
  assign inc = press[1] && !press[0] && run && rate != 2'd3;
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state <= RUN;
      paused <= 1'b0;
      rate <= 2'b10;
      rate_changed <= 1'b0;
      g1 <= 1'b0;
      g2 <= 1'b0;
      g3 <= 1'b0;
      tick <= 1'b0;
    end else begin
      g1 <= bus.clk_game;
      g2 <= g1;
      g3 <= g2;
      tick <= g2 && !g3 && run;
      state <= press[2] ? (run ? PAUSED : RUN) : state;
      paused <= press[2] ? run : !run;
      rate <= dec ? rate - 2'd1 : inc ? rate + 2'd1 : rate;
      rate_changed <= dec || inc;
    end
  assign bus.clk_rate = rate;
  assign bus.tick = tick;
  assign bus.paused = paused;
  assign bus.rate_changed = rate_changed;
endmodule

// File: tb/tb_game_speed_ctrl.sv
// tb_game_speed_ctrl: table-driven button vectors with expectation queue, plus tick, bounce and reset sequences
module tb_game_speed_ctrl;
  typedef struct {logic f; logic s; logic p; int rate; int paused; int chg;} vec_t;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int n_cmp = 0;
  int n_bad = 0;
  int tick_cnt = 0;
  int rc_cnt = 0;
  int rc0, t0;
  vec_t tbl [15];
  vec_t sb [$];
  vec_t e;
  game_speed_ctrl_if bus ();
  game_speed_ctrl #(.DEBOUNCE_CYCLES(4)) dut (.clk(clk), .rst(rst), .bus(bus));
  always #5 clk = ~clk;
  always @(negedge clk) begin
    tick_cnt += int'(bus.tick);
    rc_cnt += int'(bus.rate_changed);
  end
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic chk(input string n, input int a, input int x);
    n_cmp++;
    if (a != x) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", n, a, x);
    end
  endtask
  task automatic set_btn(input logic f, input logic s, input logic p);
    bus.btn_faster = f;
    bus.btn_slower = s;
    bus.btn_pause = p;
  endtask
  task automatic game_periods(input int n);
    repeat (n) begin
      bus.clk_game = 1'b1;
      repeat (8) step();
      bus.clk_game = 1'b0;
      repeat (8) step();
    end
  endtask
  task automatic run_tick_test();
    int c;
    bus.clk_game = 1'b1;
    step();
    chk("tick_e1", int'(bus.tick), 0);
    step();
    chk("tick_e2", int'(bus.tick), 0);
    step();
    chk("tick_e3", int'(bus.tick), 1);
    step();
    chk("tick_e4", int'(bus.tick), 0);
    repeat (4) step();
    bus.clk_game = 1'b0;
    repeat (8) step();
    c = tick_cnt;
    game_periods(3);
    chk("run_ticks", tick_cnt - c, 3);
  endtask
  initial begin
    set_btn(0, 0, 0);
    bus.clk_game = 1'b0;
    tbl[0]  = '{1'b1, 1'b0, 1'b0, 1, 0, 1};
    tbl[1]  = '{1'b1, 1'b0, 1'b0, 0, 0, 1};
    tbl[2]  = '{1'b1, 1'b0, 1'b0, 0, 0, 0};
    tbl[3]  = '{1'b0, 1'b1, 1'b0, 1, 0, 1};
    tbl[4]  = '{1'b0, 1'b1, 1'b0, 2, 0, 1};
    tbl[5]  = '{1'b0, 1'b1, 1'b0, 3, 0, 1};
    tbl[6]  = '{1'b0, 1'b1, 1'b0, 3, 0, 0};
    tbl[7]  = '{1'b1, 1'b1, 1'b0, 3, 0, 0};
    tbl[8]  = '{1'b1, 1'b0, 1'b0, 2, 0, 1};
    tbl[9]  = '{1'b0, 1'b0, 1'b1, 2, 1, 0};
    tbl[10] = '{1'b1, 1'b0, 1'b0, 2, 1, 0};
    tbl[11] = '{1'b0, 1'b1, 1'b0, 2, 1, 0};
    tbl[12] = '{1'b0, 1'b0, 1'b1, 2, 0, 0};
    tbl[13] = '{1'b1, 1'b0, 1'b1, 1, 1, 1};
    tbl[14] = '{1'b0, 1'b0, 1'b1, 1, 0, 0};
    repeat (3) step();
    rst = 1'b0;
    for (int i = 0; i < 10; i++) begin
      step();
      chk("rst_rate", int'(bus.clk_rate), 2);
      chk("rst_paused", int'(bus.paused), 0);
      chk("rst_tick", int'(bus.tick), 0);
      chk("rst_rc", int'(bus.rate_changed), 0);
    end
    rc0 = rc_cnt;
    for (int w = 1; w <= 3; w++) begin
      bus.btn_faster = 1'b1;
      repeat (w) step();
      bus.btn_faster = 1'b0;
      repeat (3) step();
    end
    repeat (10) step();
    chk("bounce_rate", int'(bus.clk_rate), 2);
    chk("bounce_rc", rc_cnt - rc0, 0);
    for (int i = 0; i < 15; i++) begin
      if (i == 10) begin
        t0 = tick_cnt;
        game_periods(3);
        chk("paused_ticks", tick_cnt - t0, 0);
      end
      if (i == 13) run_tick_test();
      sb.push_back(tbl[i]);
      rc0 = rc_cnt;
      set_btn(tbl[i].f, tbl[i].s, tbl[i].p);
      repeat (7) step();
      e = sb.pop_front();
      chk($sformatf("v%0d_rate", i), int'(bus.clk_rate), e.rate);
      chk($sformatf("v%0d_paused", i), int'(bus.paused), e.paused);
      chk($sformatf("v%0d_rc", i), int'(bus.rate_changed), e.chg);
      repeat (13) step();
      set_btn(0, 0, 0);
      repeat (10) step();
      chk($sformatf("v%0d_rc_count", i), rc_cnt - rc0, e.chg);
      chk($sformatf("v%0d_rate_hold", i), int'(bus.clk_rate), e.rate);
    end
    bus.btn_slower = 1'b1;
    repeat (3) step();
    rst = 1'b1;
    #1;
    chk("async_rst_rate", int'(bus.clk_rate), 2);
    repeat (2) step();
    rst = 1'b0;
    rc0 = rc_cnt;
    repeat (2) step();
    bus.btn_slower = 1'b0;
    repeat (15) step();
    chk("mid_rst_rate", int'(bus.clk_rate), 2);
    chk("mid_rst_rc", rc_cnt - rc0, 0);
    chk("mid_rst_paused", int'(bus.paused), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
